// File: rtl/core_inst_seq_if.sv
// core_inst_seq_if: control/instruction bundle between the core_inst_seq
// sequencer and its environment (testbench or core wrapper).
//   start       env -> seq  one-cycle pass request
//   col_c_mode  env -> seq  combined-column normalization select (sampled with start)
//   fifo_valid  env -> seq  OFIFO has a full row at its head
//   inst        seq -> env  27-bit registered instruction word for core.inst
//   load_idx    seq -> env  mem_in vector index to present during vmem/nmem writes
//   busy        seq -> env  high outside IDLE
//   done        seq -> env  one-cycle end-of-pass pulse
interface core_inst_seq_if;
  logic        start;
  logic        col_c_mode;
  logic        fifo_valid;
  logic [26:0] inst;
  logic [3:0]  load_idx;
  logic        busy;
  logic        done;

  modport master (
    input  start, col_c_mode, fifo_valid,
    output inst, load_idx, busy, done
  );

  modport slave (
    output start, col_c_mode, fifo_valid,
    input  inst, load_idx, busy, done
  );
endinterface

// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer for core. A start pulse in IDLE runs
// one full pass: Q/K load, kernel load, execute, OFIFO drain into psum memory,
// then normalization sum and divide passes, ending with a one-cycle done.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    core_inst_seq_if.master (start/col_c_mode/fifo_valid in;
//          inst/load_idx/busy/done out, all registered)
module core_inst_seq #(
  parameter int col = 8,
  parameter int nq  = 8,
  parameter int nk  = 8
) (
  input  logic              clk,
  input  logic              reset,
  core_inst_seq_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOADQ,
    S_LOADK,
    S_KLOAD,
    S_EXEC,
    S_DRAIN,
    S_SUM,
    S_DIV,
    S_DONE
  } state_t;

  // Counter is one bit wider than the address fields: EXEC/SUM/DIV run past
  // nq-1 (up to nq+2 = 18 cycles when nq=16). Addresses use the low 4 bits.
  localparam logic [4:0] NQ_LAST   = 5'(nq - 1);
  localparam logic [4:0] NK_LAST   = 5'(nk - 1);
  localparam logic [4:0] KLOAD_END = 5'(col);
  localparam logic [4:0] EXEC_END  = 5'(nq);
  localparam logic [4:0] NQ_W      = 5'(nq);
  localparam logic [4:0] COL_W     = 5'(col);

  state_t      state_q, state_d;
  logic [4:0]  i_q, i_d;
  logic        col_c_q, col_c_d;
  logic [26:0] inst_q, inst_d;
  logic [3:0]  load_idx_q, load_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  norm_last;

  // Instruction word for a given (state, counter) pair; fv is the transfer
  // decision for DRAIN.
  function automatic logic [26:0] decode(input state_t s, input logic [4:0] i,
                                         input logic cc, input logic fv);
    logic [26:0] w;
    logic [4:0]  d;
    logic [4:0]  na;
    w  = '0;
    d  = cc ? 5'd2 : 5'd1;
    na = i - d;
    case (s)
      S_LOADQ: begin
        w[4]     = 1'b1;
        w[15:12] = i[3:0];
      end
      S_LOADK: begin
        w[2]     = 1'b1;
        w[15:12] = i[3:0];
      end
      S_KLOAD: begin
        if (i < COL_W) begin
          w[3]     = 1'b1;
          w[15:12] = i[3:0];
        end
        if (i >= 5'd1) w[6] = 1'b1;
      end
      S_EXEC: begin
        if (i < NQ_W) begin
          w[5]     = 1'b1;
          w[15:12] = i[3:0];
        end
        if (i >= 5'd1) w[7] = 1'b1;
      end
      S_DRAIN: begin
        if (fv) begin
          w[16]   = 1'b1;
          w[0]    = 1'b1;
          w[11:8] = i[3:0];
        end
      end
      S_SUM: begin
        w[17] = cc;
        if (i < NQ_W) begin
          w[1]    = 1'b1;
          w[11:8] = i[3:0];
        end
        if (i >= d) w[18] = 1'b1;
      end
      S_DIV: begin
        w[17] = cc;
        if (i < NQ_W) begin
          w[1]    = 1'b1;
          w[11:8] = i[3:0];
        end
        if (i >= d) begin
          w[19]    = 1'b1;
          w[20]    = 1'b1;
          w[22]    = 1'b1;
          w[26:23] = na[3:0];
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  // Outputs are decoded from the next state/counter so that they are
  // registered yet line up with the cycle the state is entered.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q + 5'd1;
    col_c_d   = col_c_q;
    norm_last = col_c_q ? 5'(nq + 1) : 5'(nq);
    case (state_q)
      S_IDLE: begin
        i_d = '0;
        if (bus.start) begin
          state_d = S_LOADQ;
          col_c_d = bus.col_c_mode;
        end
      end
      S_LOADQ: if (i_q == NQ_LAST)   begin state_d = S_LOADK; i_d = '0; end
      S_LOADK: if (i_q == NK_LAST)   begin state_d = S_KLOAD; i_d = '0; end
      S_KLOAD: if (i_q == KLOAD_END) begin state_d = S_EXEC;  i_d = '0; end
      S_EXEC:  if (i_q == EXEC_END)  begin state_d = S_DRAIN; i_d = '0; end
      S_DRAIN: begin
        // The counter advances only on a cycle that actually carried a transfer.
        if (!inst_q[16])          i_d = i_q;
        else if (i_q == NQ_LAST) begin state_d = S_SUM; i_d = '0; end
      end
      S_SUM:   if (i_q == norm_last) begin state_d = S_DIV;  i_d = '0; end
      S_DIV:   if (i_q == norm_last) begin state_d = S_DONE; i_d = '0; end
      S_DONE:  begin state_d = S_IDLE; i_d = '0; end
      default: begin state_d = S_IDLE; i_d = '0; end
    endcase
    inst_d     = decode(state_d, i_d, col_c_d, bus.fifo_valid);
    load_idx_d = (state_d == S_LOADQ || state_d == S_LOADK) ? i_d[3:0] : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      col_c_q    <= 1'b0;
      inst_q     <= '0;
      load_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      col_c_q    <= col_c_d;
      inst_q     <= inst_d;
      load_idx_q <= load_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.inst     = inst_q;
  assign bus.load_idx = load_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: directed bench for core_inst_seq. Two instances share the
// clock/reset: u0 with default parameters and u1 with nq=nk=16. A phase-list
// model builds the expected per-cycle instruction trace of a pass, and literal
// expectations pin pass length, pulse counts and address sequences.
module tb_core_inst_seq;

  logic clk;
  logic reset;

  core_inst_seq_if b0 ();
  core_inst_seq_if b1 ();

  core_inst_seq #(.col(8), .nq(8), .nk(8)) u0 (
    .clk(clk), .reset(reset), .bus(b0.master)
  );
  core_inst_seq #(.col(8), .nq(16), .nk(16)) u1 (
    .clk(clk), .reset(reset), .bus(b1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  logic [26:0] exp_inst[$];
  logic [3:0]  exp_lidx[$];

  // statistics gathered from DUT outputs during a pass
  int n6, n7, nnw, nx, n17, first_prd, first_acc, done_k, max_vn, max_pa, last_na;
  logic [26:0] abort_inst;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic bit fv(input int m, input int c);
    if (m == 0) return 1'b1;
    return (c % 3 == 0);
  endfunction

  // Expected trace: word at position p is visible in cycle p+1 after start.
  task automatic build_model(input int nq, input int nk, input int col,
                             input bit cc, input int fvm);
    logic [26:0] w;
    int d, x;
    exp_inst.delete();
    exp_lidx.delete();
    for (int j = 0; j < nq; j++) begin
      w = '0; w[4] = 1'b1; w[15:12] = 4'(j);
      exp_inst.push_back(w); exp_lidx.push_back(4'(j));
    end
    for (int j = 0; j < nk; j++) begin
      w = '0; w[2] = 1'b1; w[15:12] = 4'(j);
      exp_inst.push_back(w); exp_lidx.push_back(4'(j));
    end
    for (int j = 0; j <= col; j++) begin
      w = '0;
      if (j < col) begin w[3] = 1'b1; w[15:12] = 4'(j); end
      if (j >= 1) w[6] = 1'b1;
      exp_inst.push_back(w); exp_lidx.push_back(4'd0);
    end
    for (int j = 0; j <= nq; j++) begin
      w = '0;
      if (j < nq) begin w[5] = 1'b1; w[15:12] = 4'(j); end
      if (j >= 1) w[7] = 1'b1;
      exp_inst.push_back(w); exp_lidx.push_back(4'd0);
    end
    x = 0;
    while (x < nq) begin
      w = '0;
      if (fv(fvm, exp_inst.size())) begin
        w[16] = 1'b1; w[0] = 1'b1; w[11:8] = 4'(x); x++;
      end
      exp_inst.push_back(w); exp_lidx.push_back(4'd0);
    end
    d = cc ? 2 : 1;
    for (int j = 0; j < nq + d; j++) begin
      w = '0; w[17] = cc;
      if (j < nq) begin w[1] = 1'b1; w[11:8] = 4'(j); end
      if (j >= d) w[18] = 1'b1;
      exp_inst.push_back(w); exp_lidx.push_back(4'd0);
    end
    for (int j = 0; j < nq + d; j++) begin
      w = '0; w[17] = cc;
      if (j < nq) begin w[1] = 1'b1; w[11:8] = 4'(j); end
      if (j >= d) begin
        w[19] = 1'b1; w[20] = 1'b1; w[22] = 1'b1; w[26:23] = 4'(j - d);
      end
      exp_inst.push_back(w); exp_lidx.push_back(4'd0);
    end
    exp_inst.push_back('0); exp_lidx.push_back(4'd0);
  endtask

  task automatic drive(input int which, input logic st, input logic cc, input logic f);
    b0.start = 1'b0; b0.col_c_mode = 1'b0; b0.fifo_valid = 1'b0;
    b1.start = 1'b0; b1.col_c_mode = 1'b0; b1.fifo_valid = 1'b0;
    if (which == 0) begin
      b0.start = st; b0.col_c_mode = cc; b0.fifo_valid = f;
    end else begin
      b1.start = st; b1.col_c_mode = cc; b1.fifo_valid = f;
    end
  endtask

  task automatic sample(input int which, output logic [26:0] gi, output logic [3:0] gl,
                        output logic gb, output logic gd);
    if (which == 0) begin
      gi = b0.inst; gl = b0.load_idx; gb = b0.busy; gd = b0.done;
    end else begin
      gi = b1.inst; gl = b1.load_idx; gb = b1.busy; gd = b1.done;
    end
  endtask

  task automatic run_pass(input int which, input bit cc, input int fvm,
                          input int abort_k, input int ign_a, input int ign_b);
    int len;
    bit aborted;
    logic [26:0] gi;
    logic [3:0]  gl;
    logic        gb, gd;
    build_model(which ? 16 : 8, which ? 16 : 8, 8, cc, fvm);
    len = exp_inst.size();
    n6 = 0; n7 = 0; nnw = 0; nx = 0; n17 = 0; first_prd = -1; first_acc = -1;
    done_k = -1; max_vn = 0; max_pa = 0; last_na = -1; aborted = 1'b0;
    @(posedge clk); #1;
    drive(which, 1'b1, cc, fv(fvm, 0));
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      // col_c_mode flips after the start cycle: only the latched value may matter
      drive(which, (k == ign_a || k == ign_b), ~cc, fv(fvm, k));
      @(negedge clk);
      sample(which, gi, gl, gb, gd);
      check($sformatf("inst_c%0d", k), 32'(gi), 32'(exp_inst[k-1]));
      check($sformatf("load_idx_c%0d", k), 32'(gl), 32'(exp_lidx[k-1]));
      check($sformatf("busy_c%0d", k), 32'(gb), 32'd1);
      check($sformatf("done_c%0d", k), 32'(gd), (k == len) ? 32'd1 : 32'd0);
      if (gi[6]) n6++;
      if (gi[7]) n7++;
      if (gi[17]) n17++;
      if (gi[22]) begin
        check("norm_add_seq", 32'(gi[26:23]), 32'(nnw));
        nnw++;
        last_na = int'(gi[26:23]);
      end
      if (gi[16]) begin
        check("pmem_add_seq", 32'(gi[11:8]), 32'(nx));
        nx++;
      end
      if ((gi[5] | gi[4] | gi[3] | gi[2]) && int'(gi[15:12]) > max_vn) max_vn = int'(gi[15:12]);
      if ((gi[1] | gi[0]) && int'(gi[11:8]) > max_pa) max_pa = int'(gi[11:8]);
      if (gi[1] && first_prd < 0) first_prd = k;
      if (gi[18] && first_acc < 0) first_acc = k;
      if (gd) done_k = k;
      if (k == abort_k) begin
        abort_inst = gi;
        #1 reset = 1'b1;
        #1 sample(which, gi, gl, gb, gd);
        check("abort_inst", 32'(gi), 32'd0);
        check("abort_busy", 32'(gb), 32'd0);
        check("abort_done", 32'(gd), 32'd0);
        check("abort_load_idx", 32'(gl), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        drive(which, 1'b0, 1'b0, 1'b0);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        drive(which, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        sample(which, gi, gl, gb, gd);
        check("idle_inst", 32'(gi), 32'd0);
        check("idle_busy", 32'(gb), 32'd0);
        check("idle_done", 32'(gd), 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_inst", 32'(b0.inst), 32'd0);
    check("rst_busy", 32'(b0.busy), 32'd0);
    check("rst_done", 32'(b0.done), 32'd0);
    check("rst_load_idx", 32'(b0.load_idx), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // default pass, fifo_valid always high
    run_pass(0, 1'b0, 0, -1, -1, -1);
    check("len_default", 32'(done_k), 32'd61);
    check("kload_pulses", 32'(n6), 32'd8);
    check("exec_pulses", 32'(n7), 32'd8);
    check("norm_wr_count", 32'(nnw), 32'd8);
    check("col_c_bits_off", 32'(n17), 32'd0);

    // combined-column normalization
    run_pass(0, 1'b1, 0, -1, -1, -1);
    check("len_colc", 32'(done_k), 32'd63);
    check("acc_delay_colc", 32'(first_acc - first_prd), 32'd2);
    check("col_c_bits_on", 32'(n17), 32'd20);

    // DRAIN with fifo_valid pattern 1,0,0,1,...
    run_pass(0, 1'b0, 1, -1, -1, -1);
    check("drain_xfers", 32'(nx), 32'd8);

    // reset in EXEC at i=4 (cycle 8+8+9+4+1)
    run_pass(0, 1'b0, 0, 30, -1, -1);
    check("abort_point", 32'(abort_inst), 32'h000040A0);

    // fresh pass after abort, with ignored starts in LOADK and DONE
    run_pass(0, 1'b0, 0, -1, 12, 61);
    check("len_after_abort", 32'(done_k), 32'd61);

    // next pass starts only from IDLE
    run_pass(0, 1'b0, 0, -1, -1, -1);
    check("len_second", 32'(done_k), 32'd61);

    // nq=nk=16 boundary addresses
    run_pass(1, 1'b0, 0, -1, -1, -1);
    check("len_16", 32'(done_k), 32'd109);
    check("max_vnmem_add", 32'(max_vn), 32'd15);
    check("max_pmem_add", 32'(max_pa), 32'd15);
    check("last_norm_add", 32'(last_na), 32'd15);
    check("norm_wr_16", 32'(nnw), 32'd16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
